// File: rtl/password_vault.sv
// password_vault: three-code password lock with setup, unlock, change-password
// and a timed lockout after MAX_TRIES consecutive failed attempts.
//
// Ports:
//   CLK        in   system clock, all state changes on rising edge
//   RST        in   synchronous active-high reset, highest priority
//   SW         in   PW_W-bit code on the switches
//   ENTER      in   single-cycle enter pulse
//   SLOT       in   0-2 = code position, 3 = submit
//   CHG        in   change-password request, used on a submit in OPEN
//   UNLOCKED   out  high while in OPEN
//   LOCKED_OUT out  high while in LOCKOUT
//   PASS       out  one-cycle pulse on a successful compare
//   FAIL       out  one-cycle pulse on a failed compare
//   FAILS      out  consecutive-failure count
//   VSTATE     out  state code: SETUP=0, ARMED=1, OPEN=2, LOCKOUT=3
module password_vault #(
  parameter int unsigned PW_W        = 8,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCKOUT_CYC = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PW_W-1:0] SW,
  input  logic            ENTER,
  input  logic [1:0]      SLOT,
  input  logic            CHG,
  output logic            UNLOCKED,
  output logic            LOCKED_OUT,
  output logic            PASS,
  output logic            FAIL,
  output logic [2:0]      FAILS,
  output logic [1:0]      VSTATE
);

  localparam int unsigned NumSlots = 3;
  localparam int unsigned TimerW   = 16;
  localparam logic [2:0]        MaxTries = 3'(MAX_TRIES);
  localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCKOUT_CYC);

  typedef enum logic [1:0] {
    S_SETUP   = 2'd0,
    S_ARMED   = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [NumSlots-1:0][PW_W-1:0]   pw_q, pw_d;
  logic [NumSlots-1:0][PW_W-1:0]   ent_q, ent_d;
  logic [2:0]                      fails_q, fails_d;
  logic [TimerW-1:0]               timer_q, timer_d;
  logic                            unlocked_q, unlocked_d;
  logic                            locked_out_q, locked_out_d;
  logic                            pass_q, pass_d;
  logic                            fail_q, fail_d;
  logic [2:0]                      fails_inc;

  // State register and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_SETUP;
      pw_q         <= '0;
      ent_q        <= '0;
      fails_q      <= 3'd0;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pw_q         <= pw_d;
      ent_q        <= ent_d;
      fails_q      <= fails_d;
      timer_q      <= timer_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d   = state_q;
    pw_d      = pw_q;
    ent_d     = ent_q;
    fails_d   = fails_q;
    timer_d   = timer_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    // Saturating increment keeps FAILS within MAX_TRIES
    fails_inc = (fails_q >= MaxTries) ? MaxTries : fails_q + 3'd1;

    if (state_q == S_LOCKOUT) begin
      // ENTER is ignored for the whole dwell, including the final cycle
      timer_d = timer_q - TimerW'(1);
      if (timer_q <= TimerW'(1)) begin
        state_d = S_ARMED;
        fails_d = 3'd0;
        ent_d   = '0;
        timer_d = '0;
      end
    end else if (ENTER) begin
      if (SLOT != 2'd3) begin
        for (int unsigned i = 0; i < NumSlots; i++) begin
          if (SLOT == 2'(i)) ent_d[i] = SW;
        end
      end else begin
        // Every submit consumes the entry registers
        ent_d = '0;
        case (state_q)
          S_SETUP: begin
            pw_d    = ent_q;
            state_d = S_ARMED;
          end
          S_ARMED: begin
            if (ent_q == pw_q) begin
              state_d = S_OPEN;
              pass_d  = 1'b1;
              fails_d = 3'd0;
            end else begin
              fail_d  = 1'b1;
              fails_d = fails_inc;
              if (fails_inc == MaxTries) begin
                state_d = S_LOCKOUT;
                timer_d = LockLoad;
              end
            end
          end
          S_OPEN: begin
            if (CHG) pw_d = ent_q;
            state_d = S_ARMED;
          end
          default: state_d = state_q;
        endcase
      end
    end

    unlocked_d   = (state_d == S_OPEN);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  assign UNLOCKED   = unlocked_q;
  assign LOCKED_OUT = locked_out_q;
  assign PASS       = pass_q;
  assign FAIL       = fail_q;
  assign FAILS      = fails_q;
  assign VSTATE     = state_q;

endmodule

// File: tb/tb_password_vault.sv
// tb_password_vault: directed-vector bench for password_vault (default params).
module tb_password_vault;

  logic       CLK;
  logic       RST;
  logic [7:0] SW;
  logic       ENTER;
  logic [1:0] SLOT;
  logic       CHG;
  logic       unlocked_o, locked_out_o, pass_o, fail_o;
  logic [2:0] fails_o;
  logic [1:0] vstate_o;

  int n_vec = 0;
  int n_err = 0;

  password_vault #(.PW_W(8), .MAX_TRIES(3), .LOCKOUT_CYC(10)) dut (
    .CLK(CLK), .RST(RST), .SW(SW), .ENTER(ENTER), .SLOT(SLOT), .CHG(CHG),
    .UNLOCKED(unlocked_o), .LOCKED_OUT(locked_out_o), .PASS(pass_o),
    .FAIL(fail_o), .FAILS(fails_o), .VSTATE(vstate_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output snapshot {VSTATE, UNLOCKED, LOCKED_OUT, PASS, FAIL, FAILS}
  function automatic logic [8:0] snap();
    return {vstate_o, unlocked_o, locked_out_o, pass_o, fail_o, fails_o};
  endfunction

  function automatic logic [8:0] mk(input logic [1:0] vs, input logic ul,
                                    input logic lo, input logic p,
                                    input logic f, input logic [2:0] fl);
    return {vs, ul, lo, p, f, fl};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_enter(input logic [1:0] slot, input logic [7:0] sw, input logic chg);
    SLOT = slot; SW = sw; CHG = chg; ENTER = 1'b1;
    @(posedge CLK);
    #1;
    ENTER = 1'b0; CHG = 1'b0;
  endtask

  task automatic code_submit(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic chg);
    do_enter(2'd0, a, 1'b0);
    do_enter(2'd1, b, 1'b0);
    do_enter(2'd2, c, 1'b0);
    do_enter(2'd3, 8'h00, chg);
  endtask

  task automatic test_reset();
    RST = 1'b1; ENTER = 1'b0; SW = '0; SLOT = '0; CHG = 1'b0;
    idle(2);
    n_vec++;
    if (snap() !== mk(2'd0, 0, 0, 0, 0, 3'd0)) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", snap(), mk(2'd0, 0, 0, 0, 0, 3'd0));
    end
    n_vec++;
    if (dut.pw_q !== 24'h0 || dut.ent_q !== 24'h0) begin
      n_err++; $display("FAIL reset_regs: got pw %h ent %h want 0", dut.pw_q, dut.ent_q);
    end
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_setup_unlock();
    code_submit(8'h12, 8'h34, 8'h56, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd1, 0, 0, 0, 0, 3'd0)) begin
      n_err++; $display("FAIL setup_armed: got %h want %h", snap(), mk(2'd1, 0, 0, 0, 0, 3'd0));
    end
    n_vec++;
    if (dut.pw_q !== 24'h563412 || dut.ent_q !== 24'h0) begin
      n_err++; $display("FAIL setup_pw: got pw %h ent %h want 563412/0", dut.pw_q, dut.ent_q);
    end
    code_submit(8'h12, 8'h34, 8'h56, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd2, 1, 0, 1, 0, 3'd0)) begin
      n_err++; $display("FAIL unlock_pass: got %h want %h", snap(), mk(2'd2, 1, 0, 1, 0, 3'd0));
    end
    idle(1);
    n_vec++;
    if (snap() !== mk(2'd2, 1, 0, 0, 0, 3'd0)) begin
      n_err++; $display("FAIL pass_one_cycle: got %h want %h", snap(), mk(2'd2, 1, 0, 0, 0, 3'd0));
    end
  endtask

  task automatic test_lockout();
    int cnt;
    do_enter(2'd3, 8'h00, 1'b0);  // relock from OPEN, PW kept
    n_vec++;
    if (snap() !== mk(2'd1, 0, 0, 0, 0, 3'd0) || dut.pw_q !== 24'h563412) begin
      n_err++; $display("FAIL relock: got %h pw %h want %h pw 563412", snap(), dut.pw_q, mk(2'd1, 0, 0, 0, 0, 3'd0));
    end
    for (int k = 1; k <= 3; k++) begin
      logic [8:0] exp;
      code_submit(8'h12, 8'h34, 8'h57, 1'b0);
      exp = (k == 3) ? mk(2'd3, 0, 1, 0, 1, 3'd3) : mk(2'd1, 0, 0, 0, 1, 3'(k));
      n_vec++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL bad_try_%0d: got %h want %h", k, snap(), exp);
      end
    end
    cnt = 0;
    for (int i = 0; i < 40 && locked_out_o; i++) begin
      cnt++;
      idle(1);
    end
    n_vec++;
    if (cnt != 10) begin
      n_err++; $display("FAIL lockout_dwell: got %0d cycles want 10", cnt);
    end
    n_vec++;
    if (snap() !== mk(2'd1, 0, 0, 0, 0, 3'd0)) begin
      n_err++; $display("FAIL lockout_exit: got %h want %h", snap(), mk(2'd1, 0, 0, 0, 0, 3'd0));
    end
  endtask

  task automatic test_ignore_lockout();
    for (int k = 0; k < 3; k++) code_submit(8'h00, 8'h00, 8'h01, 1'b0);
    // Now at lockout cycle 1; four ignored ENTERs occupy cycles 1-4
    for (int s = 0; s < 4; s++) begin
      do_enter(2'(s), 8'hA0 + 8'(s), 1'b0);
      n_vec++;
      if (snap() !== mk(2'd3, 0, 1, 0, 0, 3'd3) || dut.ent_q !== 24'h0) begin
        n_err++; $display("FAIL lock_ignore_slot%0d: got %h ent %h want %h ent 0", s, snap(), dut.ent_q, mk(2'd3, 0, 1, 0, 0, 3'd3));
      end
    end
    idle(5);  // sampling point of lockout cycle 10
    n_vec++;
    if (snap() !== mk(2'd3, 0, 1, 0, 0, 3'd3)) begin
      n_err++; $display("FAIL lock_final_cycle: got %h want %h", snap(), mk(2'd3, 0, 1, 0, 0, 3'd3));
    end
    do_enter(2'd0, 8'h12, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd1, 0, 0, 0, 0, 3'd0) || dut.ent_q !== 24'h0) begin
      n_err++; $display("FAIL lock_final_enter: got %h ent %h want %h ent 0", snap(), dut.ent_q, mk(2'd1, 0, 0, 0, 0, 3'd0));
    end
  endtask

  task automatic test_change_pw();
    code_submit(8'h12, 8'h34, 8'h56, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd2, 1, 0, 1, 0, 3'd0)) begin
      n_err++; $display("FAIL chg_open: got %h want %h", snap(), mk(2'd2, 1, 0, 1, 0, 3'd0));
    end
    code_submit(8'hAA, 8'hBB, 8'hCC, 1'b1);
    n_vec++;
    if (snap() !== mk(2'd1, 0, 0, 0, 0, 3'd0) || dut.pw_q !== 24'hCCBBAA) begin
      n_err++; $display("FAIL chg_store: got %h pw %h want %h pw ccbbaa", snap(), dut.pw_q, mk(2'd1, 0, 0, 0, 0, 3'd0));
    end
    code_submit(8'hAA, 8'hBB, 8'hCC, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd2, 1, 0, 1, 0, 3'd0)) begin
      n_err++; $display("FAIL chg_new_unlock: got %h want %h", snap(), mk(2'd2, 1, 0, 1, 0, 3'd0));
    end
    do_enter(2'd3, 8'h00, 1'b0);
    code_submit(8'h12, 8'h34, 8'h56, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd1, 0, 0, 0, 1, 3'd1)) begin
      n_err++; $display("FAIL chg_old_rejected: got %h want %h", snap(), mk(2'd1, 0, 0, 0, 1, 3'd1));
    end
  endtask

  task automatic test_fail_count();
    code_submit(8'hAA, 8'hBB, 8'hCC, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd2, 1, 0, 1, 0, 3'd0)) begin
      n_err++; $display("FAIL fc_clear: got %h want %h", snap(), mk(2'd2, 1, 0, 1, 0, 3'd0));
    end
    do_enter(2'd3, 8'h00, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      code_submit(8'hAA, 8'hBB, 8'hCD, 1'b0);
      n_vec++;
      if (snap() !== mk(2'd1, 0, 0, 0, 1, 3'(k))) begin
        n_err++; $display("FAIL fc_try_%0d: got %h want %h", k, snap(), mk(2'd1, 0, 0, 0, 1, 3'(k)));
      end
    end
    // Inputs wiggle with ENTER low: nothing may change
    for (int i = 0; i < 3; i++) begin
      SW = 8'h5A ^ 8'(i); SLOT = 2'(i); CHG = 1'b1;
      idle(1);
    end
    CHG = 1'b0;
    n_vec++;
    if (snap() !== mk(2'd1, 0, 0, 0, 0, 3'd2) || dut.ent_q !== 24'h0) begin
      n_err++; $display("FAIL hold_no_enter: got %h ent %h want %h ent 0", snap(), dut.ent_q, mk(2'd1, 0, 0, 0, 0, 3'd2));
    end
  endtask

  task automatic test_reset_mid();
    code_submit(8'h00, 8'h00, 8'h00, 1'b0);
    n_vec++;
    if (snap() !== mk(2'd3, 0, 1, 0, 1, 3'd3)) begin
      n_err++; $display("FAIL rm_lockout: got %h want %h", snap(), mk(2'd3, 0, 1, 0, 1, 3'd3));
    end
    idle(3);  // lockout cycle 4
    RST = 1'b1; ENTER = 1'b1; SLOT = 2'd3;  // reset must win over ENTER
    idle(1);
    RST = 1'b0; ENTER = 1'b0;
    n_vec++;
    if (snap() !== mk(2'd0, 0, 0, 0, 0, 3'd0) || dut.pw_q !== 24'h0) begin
      n_err++; $display("FAIL rm_reset: got %h pw %h want %h pw 0", snap(), dut.pw_q, mk(2'd0, 0, 0, 0, 0, 3'd0));
    end
    idle(1);
    n_vec++;
    if (snap() !== mk(2'd0, 0, 0, 0, 0, 3'd0)) begin
      n_err++; $display("FAIL rm_no_residual: got %h want %h", snap(), mk(2'd0, 0, 0, 0, 0, 3'd0));
    end
    do_enter(2'd1, 8'h77, 1'b0);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    n_vec++;
    if (dut.ent_q !== 24'h0 || snap() !== mk(2'd0, 0, 0, 0, 0, 3'd0)) begin
      n_err++; $display("FAIL rm_mid_entry: got %h ent %h want %h ent 0", snap(), dut.ent_q, mk(2'd0, 0, 0, 0, 0, 3'd0));
    end
  endtask

  initial begin
    test_reset();
    test_setup_unlock();
    test_lockout();
    test_ignore_lockout();
    test_change_pw();
    test_fail_count();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
